// File: rtl/int_adder_driver.sv
// Clocked valid/ready bridge around a dual-rail ripple adder, FP (RZ) or TP (transition) encoding.
// Define INT_ADDER_DRIVER_SYNC_EN to pass the returned rails through two-flop synchronisers.
module int_adder_driver #(
  parameter ENC = "TP",
  parameter int WIDTH = 1,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_s,
  output logic                 out_c,
  output logic                 out_err,
  output logic                 en,
  output logic [WIDTH*2-1:0]   a_dr,
  output logic [WIDTH*2-1:0]   b_dr,
  output logic [1:0]           c_in_dr,
  input  logic [WIDTH*2-1:0]   s_dr,
  input  logic [1:0]           c_out_dr
);
  localparam int RAIL_NUM = 2;
  localparam int RW = (WIDTH + 1) * RAIL_NUM;
  localparam bit IS_FP = (ENC == "FP");
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_RTZ  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  if (ENC != "FP" && ENC != "TP") begin : g_bad_enc
    $error("int_adder_driver: ENC must be \"FP\" or \"TP\"");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("int_adder_driver: TIMEOUT must be at least 2");
  end

  logic [1:0]            state_q, state_d;
  logic [WIDTH*2-1:0]    a_dr_q, a_dr_d, b_dr_q, b_dr_d;
  logic [1:0]            c_in_dr_q, c_in_dr_d;
  logic [RW-1:0]         ref_q, ref_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]      out_s_q, out_s_d;
  logic                  out_c_q, out_c_d, out_err_q, out_err_d;
  logic                  en_q, en_d;
  logic [RW-1:0]         ret, diff;
  logic [WIDTH:0]        val;
  logic [1:0]            pair;
  logic                  done, illegal, ret_zero, timeout, leave_eval;

`ifdef INT_ADDER_DRIVER_SYNC_EN
  logic [RW-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  always_comb begin
    sync1_d = {c_out_dr, s_dr};
    sync2_d = sync1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
  assign ret = sync2_q;
`else
  assign ret = {c_out_dr, s_dr};
`endif

  // FP looks at the rails themselves; TP looks at which rails toggled since the last result.
  assign diff = IS_FP ? ret : (ret ^ ref_q);
  assign ret_zero = (ret == '0);
  assign timeout = (cnt_q == CNT_MAX);

  always_comb begin
    done = 1'b1;
    illegal = 1'b0;
    val = '0;
    pair = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      pair = diff[RAIL_NUM*i +: RAIL_NUM];
      done = done & (pair[1] ^ pair[0]);
      illegal = illegal | (&pair);
      val[i] = pair[1];
    end
  end

  always_comb begin
    state_d = state_q;
    a_dr_d = a_dr_q;
    b_dr_d = b_dr_q;
    c_in_dr_d = c_in_dr_q;
    ref_d = ref_q;
    out_s_d = out_s_q;
    out_c_d = out_c_q;
    out_err_d = out_err_q;
    en_d = 1'b1;
    leave_eval = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_EVAL;
          for (int i = 0; i < WIDTH; i++) begin
            if (IS_FP) begin
              a_dr_d[RAIL_NUM*i +: RAIL_NUM] = in_a[i] ? 2'b10 : 2'b01;
              b_dr_d[RAIL_NUM*i +: RAIL_NUM] = in_b[i] ? 2'b10 : 2'b01;
            end else begin
              a_dr_d[RAIL_NUM*i+1] = a_dr_q[RAIL_NUM*i+1] ^ in_a[i];
              a_dr_d[RAIL_NUM*i]   = a_dr_q[RAIL_NUM*i] ^ ~in_a[i];
              b_dr_d[RAIL_NUM*i+1] = b_dr_q[RAIL_NUM*i+1] ^ in_b[i];
              b_dr_d[RAIL_NUM*i]   = b_dr_q[RAIL_NUM*i] ^ ~in_b[i];
            end
          end
          if (IS_FP) begin
            c_in_dr_d = in_c ? 2'b10 : 2'b01;
          end else begin
            c_in_dr_d = c_in_dr_q ^ {in_c, ~in_c};
          end
        end
      end
      ST_EVAL: begin
        if (illegal) begin
          out_err_d = 1'b1;
          leave_eval = 1'b1;
        end else if (done) begin
          out_s_d = val[WIDTH-1:0];
          out_c_d = val[WIDTH];
          out_err_d = 1'b0;
          leave_eval = 1'b1;
        end else if (timeout) begin
          out_err_d = 1'b1;
          leave_eval = 1'b1;
        end
        // FP always returns to zero so the adder can clear, even after an error.
        if (leave_eval) begin
          if (IS_FP) begin
            a_dr_d = '0;
            b_dr_d = '0;
            c_in_dr_d = '0;
            state_d = ST_RTZ;
          end else begin
            ref_d = ret;
            state_d = ST_HOLD;
          end
        end
      end
      ST_RTZ: begin
        if (ret_zero) begin
          state_d = ST_HOLD;
        end else if (timeout) begin
          out_err_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      default: begin
        if (out_ready) state_d = ST_IDLE;
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == ST_EVAL || state_q == ST_RTZ) && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_dr_q    <= '0;
      b_dr_q    <= '0;
      c_in_dr_q <= '0;
      ref_q     <= '0;
      cnt_q     <= '0;
      out_s_q   <= '0;
      out_c_q   <= 1'b0;
      out_err_q <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_dr_q    <= a_dr_d;
      b_dr_q    <= b_dr_d;
      c_in_dr_q <= c_in_dr_d;
      ref_q     <= ref_d;
      cnt_q     <= cnt_d;
      out_s_q   <= out_s_d;
      out_c_q   <= out_c_d;
      out_err_q <= out_err_d;
      en_q      <= en_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign out_s     = out_s_q;
  assign out_c     = out_c_q;
  assign out_err   = out_err_q;
  assign en        = en_q;
  assign a_dr      = a_dr_q;
  assign b_dr      = b_dr_q;
  assign c_in_dr   = c_in_dr_q;
endmodule

// File: tb/tb_int_adder_driver.sv
// Bench for int_adder_driver: one FP and one TP instance, each around a behavioural dual-rail adder.
module tb_int_adder_driver;
  localparam int M_OK = 0, M_ILL = 1, M_SIL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic f_rst, f_in_valid, f_in_ready, f_in_c, f_out_valid, f_out_ready, f_out_c, f_out_err, f_en;
  logic [3:0] f_in_a, f_in_b, f_out_s;
  logic [7:0] f_a_dr, f_b_dr, f_s_dr;
  logic [1:0] f_c_in_dr, f_c_out_dr;
  logic t_rst, t_in_valid, t_in_ready, t_in_c, t_out_valid, t_out_ready, t_out_c, t_out_err, t_en;
  logic [3:0] t_in_a, t_in_b, t_out_s;
  logic [7:0] t_a_dr, t_b_dr, t_s_dr;
  logic [1:0] t_c_in_dr, t_c_out_dr;
  int f_mode = M_OK, t_mode = M_OK;

  int n_pass = 0, n_total = 0, lat;
  logic [5:0] exp_f_q[$];
  logic [5:0] exp_t_q[$];

  int_adder_driver #(.ENC("FP"), .WIDTH(4), .TIMEOUT(8)) u_fp (
    .clk(clk), .rst(f_rst), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .in_a(f_in_a), .in_b(f_in_b), .in_c(f_in_c), .out_valid(f_out_valid),
    .out_ready(f_out_ready), .out_s(f_out_s), .out_c(f_out_c), .out_err(f_out_err),
    .en(f_en), .a_dr(f_a_dr), .b_dr(f_b_dr), .c_in_dr(f_c_in_dr),
    .s_dr(f_s_dr), .c_out_dr(f_c_out_dr));

  int_adder_driver #(.ENC("TP"), .WIDTH(4), .TIMEOUT(8)) u_tp (
    .clk(clk), .rst(t_rst), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .in_a(t_in_a), .in_b(t_in_b), .in_c(t_in_c), .out_valid(t_out_valid),
    .out_ready(t_out_ready), .out_s(t_out_s), .out_c(t_out_c), .out_err(t_out_err),
    .en(t_en), .a_dr(t_a_dr), .b_dr(t_b_dr), .c_in_dr(t_c_in_dr),
    .s_dr(t_s_dr), .c_out_dr(t_c_out_dr));

  // Behavioural FP adder: data when every input bit is one-hot, zero when inputs are zero.
  logic f_ok, f_zero;
  logic [3:0] f_va, f_vb;
  logic [4:0] f_sum;
  always @(negedge clk) begin
    f_ok = f_c_in_dr[1] ^ f_c_in_dr[0];
    f_zero = (f_a_dr == 8'h0) && (f_b_dr == 8'h0) && (f_c_in_dr == 2'b00);
    for (int i = 0; i < 4; i++) begin
      f_ok = f_ok & (f_a_dr[2*i] ^ f_a_dr[2*i+1]) & (f_b_dr[2*i] ^ f_b_dr[2*i+1]);
      f_va[i] = f_a_dr[2*i+1];
      f_vb[i] = f_b_dr[2*i+1];
    end
    if (f_mode == M_SIL || f_zero) begin
      f_s_dr = 8'h0;
      f_c_out_dr = 2'b00;
    end else if (f_ok) begin
      f_sum = {1'b0, f_va} + {1'b0, f_vb} + {4'h0, f_c_in_dr[1]};
      for (int i = 0; i < 4; i++) f_s_dr[2*i +: 2] = f_sum[i] ? 2'b10 : 2'b01;
      f_c_out_dr = f_sum[4] ? 2'b10 : 2'b01;
      if (f_mode == M_ILL) f_s_dr[5:4] = 2'b11;
    end
  end

  // Behavioural TP adder: once every input bit has toggled exactly one rail, toggle the result rails.
  logic [7:0] t_pa = 8'h0, t_pb = 8'h0, t_da, t_db;
  logic [1:0] t_pc = 2'b00, t_dc;
  logic t_ok;
  logic [4:0] t_sum;
  initial begin
    t_s_dr = 8'h0;
    t_c_out_dr = 2'b00;
  end
  always @(negedge clk) begin
    t_da = t_a_dr ^ t_pa;
    t_db = t_b_dr ^ t_pb;
    t_dc = t_c_in_dr ^ t_pc;
    t_ok = t_dc[1] ^ t_dc[0];
    for (int i = 0; i < 4; i++) t_ok = t_ok & (t_da[2*i] ^ t_da[2*i+1]) & (t_db[2*i] ^ t_db[2*i+1]);
    if (t_ok) begin
      t_sum = 5'd0;
      for (int i = 0; i < 4; i++) t_sum = t_sum + (5'(t_da[2*i+1]) << i) + (5'(t_db[2*i+1]) << i);
      t_sum = t_sum + 5'(t_dc[1]);
      if (t_mode != M_SIL) begin
        for (int i = 0; i < 4; i++) begin
          t_s_dr[2*i+1] = t_s_dr[2*i+1] ^ t_sum[i];
          t_s_dr[2*i] = t_s_dr[2*i] ^ ~t_sum[i];
        end
        t_c_out_dr = t_c_out_dr ^ {t_sum[4], ~t_sum[4]};
      end
      t_pa = t_a_dr;
      t_pb = t_b_dr;
      t_pc = t_c_in_dr;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h required=%h", name, act, exp);
  endtask

  // Monitors: pop the expected result whenever a result handshake is about to complete.
  always @(negedge clk) begin
    if (f_out_valid && f_out_ready && !f_rst) begin
      if (exp_f_q.size() == 0) begin
        n_total++;
        $display("FAIL fp_unexpected_result got=%h required=none", {f_out_err, f_out_c, f_out_s});
      end else check("fp_result", {26'h0, f_out_err, f_out_c, f_out_s}, {26'h0, exp_f_q.pop_front()});
    end
    if (t_out_valid && t_out_ready && !t_rst) begin
      if (exp_t_q.size() == 0) begin
        n_total++;
        $display("FAIL tp_unexpected_result got=%h required=none", {t_out_err, t_out_c, t_out_s});
      end else check("tp_result", {26'h0, t_out_err, t_out_c, t_out_s}, {26'h0, exp_t_q.pop_front()});
    end
  end

  task automatic wait_f_idle();
    int n = 0;
    @(negedge clk);
    while (!f_in_ready && n < 100) begin @(negedge clk); n++; end
    if (!f_in_ready) begin n_total++; $display("FAIL fp_idle_wait in_ready=0 required=1"); end
  endtask

  task automatic wait_t_idle();
    int n = 0;
    @(negedge clk);
    while (!t_in_ready && n < 100) begin @(negedge clk); n++; end
    if (!t_in_ready) begin n_total++; $display("FAIL tp_idle_wait in_ready=0 required=1"); end
  endtask

  task automatic fp_issue(input logic [3:0] a, input logic [3:0] b, input logic c,
                          input bit push, input logic [5:0] exp);
    wait_f_idle();
    if (f_in_ready) begin
      if (push) exp_f_q.push_back(exp);
      f_in_a = a; f_in_b = b; f_in_c = c; f_in_valid = 1'b1;
      @(posedge clk);
      #1 f_in_valid = 1'b0;
    end
  endtask

  task automatic tp_issue(input logic [3:0] a, input logic [3:0] b, input logic c,
                          input bit push, input logic [5:0] exp);
    wait_t_idle();
    if (t_in_ready) begin
      if (push) exp_t_q.push_back(exp);
      t_in_a = a; t_in_b = b; t_in_c = c; t_in_valid = 1'b1;
      @(posedge clk);
      #1 t_in_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    f_rst = 1'b1; t_rst = 1'b1;
    f_in_valid = 1'b0; f_in_a = 4'h0; f_in_b = 4'h0; f_in_c = 1'b0; f_out_ready = 1'b1;
    t_in_valid = 1'b0; t_in_a = 4'h0; t_in_b = 4'h0; t_in_c = 1'b0; t_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 f_rst = 1'b0; t_rst = 1'b0;
    @(negedge clk);
    check("rst_fp_rails", {14'h0, f_a_dr, f_b_dr, f_c_in_dr}, 32'h0);
    check("rst_fp_en", f_en, 1'b0);
    check("rst_fp_outs", {f_out_valid, f_out_err, f_out_c, f_out_s}, 7'h0);
    check("rst_fp_in_ready", f_in_ready, 1'b1);
    check("rst_tp_rails", {14'h0, t_a_dr, t_b_dr, t_c_in_dr}, 32'h0);
    check("rst_tp_outs", {t_en, t_out_valid, t_out_err, t_out_c, t_out_s}, 8'h0);
    @(negedge clk);
    check("en_after_reset", {f_en, t_en}, 2'b11);

    // FP: 5 + 3 + 0 = 8; rails go data -> 00 -> HOLD.
    fp_issue(4'h5, 4'h3, 1'b0, 1'b1, 6'b0_0_1000);
    @(negedge clk);
    check("fp_drive_a", f_a_dr, 8'h66);
    check("fp_drive_b", f_b_dr, 8'h5A);
    check("fp_drive_c", f_c_in_dr, 2'b01);
    @(negedge clk);
    check("fp_rtz_rails", {14'h0, f_a_dr, f_b_dr, f_c_in_dr}, 32'h0);
    check("fp_rtz_no_valid", f_out_valid, 1'b0);
    @(negedge clk);
    check("fp_hold_valid", f_out_valid, 1'b1);

    // FP illegal code on s_dr[2]: error, result registers keep the last capture.
    f_mode = M_ILL;
    fp_issue(4'h5, 4'h3, 1'b0, 1'b1, 6'b1_0_1000);
    wait_f_idle();
    f_mode = M_OK;
    fp_issue(4'hA, 4'h7, 1'b1, 1'b1, 6'b0_1_0010);
    wait_f_idle();

    // FP reset pulse during EVAL aborts without a result.
    f_mode = M_SIL;
    fp_issue(4'h7, 4'h9, 1'b1, 1'b0, 6'h0);
    @(posedge clk);
    #1 f_rst = 1'b1;
    @(posedge clk);
    #1 f_rst = 1'b0;
    @(negedge clk);
    check("fp_midrst_rails", {14'h0, f_a_dr, f_b_dr, f_c_in_dr}, 32'h0);
    check("fp_midrst_en_valid", {f_en, f_out_valid}, 2'b00);
    check("fp_midrst_in_ready", f_in_ready, 1'b1);
    f_mode = M_OK;
    fp_issue(4'h7, 4'h9, 1'b1, 1'b1, 6'b0_1_0001);
    wait_f_idle();

    // TP: F + 1 + 0 = 0 carry 1, then 2 + 2 + 1 = 5 on top of the toggled rails.
    tp_issue(4'hF, 4'h1, 1'b0, 1'b1, 6'b0_1_0000);
    @(negedge clk);
    check("tp_drive_a1", t_a_dr, 8'hAA);
    wait_t_idle();
    tp_issue(4'h2, 4'h2, 1'b1, 1'b1, 6'b0_0_0101);
    @(negedge clk);
    check("tp_drive_a2", t_a_dr, 8'hF3);
    wait_t_idle();

    // TP back-pressure: 9 + 6 = F held in HOLD while out_ready is low.
    t_out_ready = 1'b0;
    tp_issue(4'h9, 4'h6, 1'b0, 1'b1, 6'b0_0_1111);
    lat = 0;
    while (!t_out_valid && lat < 40) begin @(negedge clk); lat++; end
    check("tp_hold_reached", t_out_valid, 1'b1);
    repeat (5) begin
      check("tp_hold_stable", {t_out_valid, t_in_ready, t_out_err, t_out_c, t_out_s}, 8'b10_0_0_1111);
      @(negedge clk);
    end
    @(posedge clk);
    #1 t_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("tp_release_idle", {t_out_valid, t_in_ready}, 2'b01);

    // TP timeout: adder never answers, error exactly 8 cycles after entering EVAL.
    t_mode = M_SIL;
    tp_issue(4'h1, 4'h1, 1'b0, 1'b1, 6'b1_0_1111);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (t_out_valid) break;
    end
    check("tp_timeout_latency", lat, 8);
    check("tp_timeout_err", t_out_err, 1'b1);
    t_mode = M_OK;
    wait_t_idle();
    tp_issue(4'h3, 4'h4, 1'b0, 1'b1, 6'b0_0_0111);
    wait_t_idle();

    repeat (3) @(negedge clk);
    check("fp_queue_drained", exp_f_q.size(), 0);
    check("tp_queue_drained", exp_t_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
